// File: rtl/pedal_pkg.sv
// -----------------------------------------------------------------------------
// pedal_pkg
// Shared types and constants for the pedal SPI sample sequencer.
//   seq_state_t : sequencer FSM states
//   DATA_W_DEF  : default sample / SPI frame width
//   SCLK_IDLE / SCLK_ACTIVE : SPI mode-0 clock levels (CPOL=0, sample on rise)
// -----------------------------------------------------------------------------
package pedal_pkg;

    localparam int DATA_W_DEF = 16;

    // Mode 0: clock idles low, data sampled on the rising edge and
    // shifted on the falling edge.
    localparam logic SCLK_IDLE   = 1'b0;
    localparam logic SCLK_ACTIVE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADC_XFER,
        ST_PRESENT,
        ST_WAIT_PROC,
        ST_DAC_XFER
    } seq_state_t;

endpackage

// File: rtl/spi_frame_engine.sv
// -----------------------------------------------------------------------------
// spi_frame_engine
// Runs one mode-0, MSB-first SPI frame per start pulse on the shared bus.
// Frame = SETUP half, DATA_W (HIGH,LOW) half pairs, HOLD half; each half is
// SCLK_DIV cycles, so the chip select is low for (2*DATA_W+2)*SCLK_DIV cycles.
// Ports:
//   clk_i, rst_n_i      clock, async active-low reset
//   start_i             begin a frame (ignored while a frame is active)
//   sel_dac_i           0: ADC frame (mosi held 0), 1: DAC frame (miso ignored)
//   tx_i                word shifted out on a DAC frame
//   miso_i / mosi_o     SPI data
//   sclk_o              SPI clock
//   adc_cs_n_o, dac_cs_n_o chip selects
//   rx_o                word shifted in on the last ADC frame
//   done_o              one-cycle pulse in the last cycle of the frame
// -----------------------------------------------------------------------------
module spi_frame_engine
    import pedal_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SCLK_DIV = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              sel_dac_i,
    input  logic [DATA_W-1:0] tx_i,
    input  logic              miso_i,
    output logic              mosi_o,
    output logic              sclk_o,
    output logic              adc_cs_n_o,
    output logic              dac_cs_n_o,
    output logic [DATA_W-1:0] rx_o,
    output logic              done_o
);

    localparam int HALVES = 2 * DATA_W + 2;
    localparam int DIV_W  = $clog2(SCLK_DIV + 1);
    localparam int HALF_W = $clog2(HALVES);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALVES - 1);

    logic              active_q;
    logic              sel_dac_q;
    logic [DIV_W-1:0]  div_q;
    logic [HALF_W-1:0] half_q;
    logic [HALF_W-1:0] half_nxt;
    logic [DATA_W-1:0] tx_sh_q;
    logic [DATA_W-1:0] rx_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              adc_cs_n_q;
    logic              dac_cs_n_q;
    logic              half_end;

    assign half_end = active_q && (div_q == DIV_LAST);
    assign half_nxt = half_q + 1'b1;
    assign done_o   = half_end && (half_q == HALF_LAST);

    assign mosi_o     = mosi_q;
    assign sclk_o     = sclk_q;
    assign adc_cs_n_o = adc_cs_n_q;
    assign dac_cs_n_o = dac_cs_n_q;
    assign rx_o       = rx_q;

    // Half index 0 is SETUP, odd indices are sclk HIGH phases, even indices
    // (>=2) are LOW phases, and the final (odd) index is HOLD, which must
    // not raise sclk.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            active_q   <= 1'b0;
            sel_dac_q  <= 1'b0;
            div_q      <= '0;
            half_q     <= '0;
            tx_sh_q    <= '0;
            rx_q       <= '0;
            sclk_q     <= SCLK_IDLE;
            mosi_q     <= 1'b0;
            adc_cs_n_q <= 1'b1;
            dac_cs_n_q <= 1'b1;
        end else if (!active_q) begin
            if (start_i) begin
                active_q   <= 1'b1;
                sel_dac_q  <= sel_dac_i;
                div_q      <= '0;
                half_q     <= '0;
                tx_sh_q    <= tx_i;
                adc_cs_n_q <= sel_dac_i;
                dac_cs_n_q <= !sel_dac_i;
                mosi_q     <= sel_dac_i & tx_i[DATA_W-1];
            end
        end else if (!half_end) begin
            div_q <= div_q + 1'b1;
        end else if (half_q == HALF_LAST) begin
            active_q   <= 1'b0;
            adc_cs_n_q <= 1'b1;
            dac_cs_n_q <= 1'b1;
            sclk_q     <= SCLK_IDLE;
            mosi_q     <= 1'b0;
        end else begin
            div_q  <= '0;
            half_q <= half_nxt;
            if (half_nxt[0] && (half_nxt != HALF_LAST)) begin
                sclk_q <= SCLK_ACTIVE;
                rx_q   <= {rx_q[DATA_W-2:0], miso_i & !sel_dac_q};
            end else begin
                sclk_q <= SCLK_IDLE;
                if (!half_nxt[0]) begin
                    tx_sh_q <= tx_sh_q << 1;
                    mosi_q  <= sel_dac_q & tx_sh_q[DATA_W-2];
                end
            end
        end
    end

endmodule

// File: rtl/spi_sample_sequencer.sv
// -----------------------------------------------------------------------------
// spi_sample_sequencer
// Once per sample period: read the ADC over SPI, hand the sample to the DSP
// (adc_valid_o/adc_ready_i), take the processed sample back
// (dac_valid_i/dac_ready_o) and write it to the DAC over the same SPI bus.
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, async active-low reset
//   enable_i                    run sequencing
//   clr_status_i                clear sticky flags (a same-cycle set wins)
//   miso_i/mosi_o/sclk_o        shared SPI bus
//   adc_cs_n_o, dac_cs_n_o      chip selects
//   adc_data_o, adc_valid_o, adc_ready_i   sample to DSP
//   dac_data_i, dac_valid_i, dac_ready_o   processed sample from DSP
//   busy_o                      FSM not idle
//   overrun_o, timeout_o        sticky status flags
//   irq_o                       one-cycle pulse per overrun/timeout event
// -----------------------------------------------------------------------------
module spi_sample_sequencer
    import pedal_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int SCLK_DIV     = 4,
    parameter int SAMPLE_DIV   = 1042,
    parameter int PROC_TIMEOUT = 512
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              enable_i,
    input  logic              clr_status_i,
    input  logic              miso_i,
    output logic              mosi_o,
    output logic              sclk_o,
    output logic              adc_cs_n_o,
    output logic              dac_cs_n_o,
    output logic [DATA_W-1:0] adc_data_o,
    output logic              adc_valid_o,
    input  logic              adc_ready_i,
    input  logic [DATA_W-1:0] dac_data_i,
    input  logic              dac_valid_i,
    output logic              dac_ready_o,
    output logic              busy_o,
    output logic              overrun_o,
    output logic              timeout_o,
    output logic              irq_o
);

    localparam int TICK_W = $clog2(SAMPLE_DIV + 1);
    localparam int TO_W   = $clog2(PROC_TIMEOUT + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(PROC_TIMEOUT - 1);

    seq_state_t        state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [DATA_W-1:0] adc_data_q;
    logic [DATA_W-1:0] last_dac_q;
    logic              overrun_q, timeout_q, irq_q;

    logic              tick;
    logic              to_hit;
    logic              ovr_evt;
    logic              to_evt;
    logic              fe_start;
    logic              fe_sel_dac;
    logic [DATA_W-1:0] fe_tx;
    logic [DATA_W-1:0] fe_rx;
    logic              fe_done;
    logic              load_adc;
    logic              load_dac;
    logic              in_present;
    logic              in_wait;

    assign in_present = (state_q == ST_PRESENT);
    assign in_wait    = (state_q == ST_WAIT_PROC);

    assign tick    = enable_i && (tick_cnt_q == TICK_LAST);
    assign to_hit  = (to_cnt_q == TO_LAST);
    assign ovr_evt = tick && (state_q != ST_IDLE);

    assign adc_data_o  = adc_data_q;
    assign adc_valid_o = in_present;
    assign dac_ready_o = in_wait;
    assign busy_o      = (state_q != ST_IDLE);
    assign overrun_o   = overrun_q;
    assign timeout_o   = timeout_q;
    assign irq_o       = irq_q;

    spi_frame_engine #(
        .DATA_W   (DATA_W),
        .SCLK_DIV (SCLK_DIV)
    ) u_fe (
        .clk_i      (wb_clk_i),
        .rst_n_i    (wb_rst_n_i),
        .start_i    (fe_start),
        .sel_dac_i  (fe_sel_dac),
        .tx_i       (fe_tx),
        .miso_i     (miso_i),
        .mosi_o     (mosi_o),
        .sclk_o     (sclk_o),
        .adc_cs_n_o (adc_cs_n_o),
        .dac_cs_n_o (dac_cs_n_o),
        .rx_o       (fe_rx),
        .done_o     (fe_done)
    );

    // Disable takes priority over both handshakes; a handshake takes
    // priority over a timeout landing in the same cycle.
    always_comb begin
        state_d    = state_q;
        fe_start   = 1'b0;
        fe_sel_dac = 1'b0;
        fe_tx      = '0;
        load_adc   = 1'b0;
        load_dac   = 1'b0;
        to_evt     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d  = ST_ADC_XFER;
                    fe_start = 1'b1;
                end
            end
            ST_ADC_XFER: begin
                if (fe_done) begin
                    if (enable_i) begin
                        state_d  = ST_PRESENT;
                        load_adc = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PRESENT: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (adc_ready_i) begin
                    state_d = ST_WAIT_PROC;
                end else if (to_hit) begin
                    state_d    = ST_DAC_XFER;
                    to_evt     = 1'b1;
                    fe_start   = 1'b1;
                    fe_sel_dac = 1'b1;
                    fe_tx      = last_dac_q;
                end
            end
            ST_WAIT_PROC: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (dac_valid_i) begin
                    state_d    = ST_DAC_XFER;
                    load_dac   = 1'b1;
                    fe_start   = 1'b1;
                    fe_sel_dac = 1'b1;
                    fe_tx      = dac_data_i;
                end else if (to_hit) begin
                    state_d    = ST_DAC_XFER;
                    to_evt     = 1'b1;
                    fe_start   = 1'b1;
                    fe_sel_dac = 1'b1;
                    fe_tx      = last_dac_q;
                end
            end
            ST_DAC_XFER: begin
                if (fe_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            to_cnt_q   <= '0;
            adc_data_q <= '0;
            last_dac_q <= '0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q <= state_d;

            if (!enable_i || tick) tick_cnt_q <= '0;
            else                   tick_cnt_q <= tick_cnt_q + 1'b1;

            // Counts cycles spent in PRESENT + WAIT_PROC; restarts at PRESENT entry.
            if (in_present || in_wait) to_cnt_q <= to_cnt_q + 1'b1;
            else                       to_cnt_q <= '0;

            if (load_adc) adc_data_q <= fe_rx;
            if (load_dac) last_dac_q <= dac_data_i;

            if (ovr_evt)           overrun_q <= 1'b1;
            else if (clr_status_i) overrun_q <= 1'b0;

            if (to_evt)            timeout_q <= 1'b1;
            else if (clr_status_i) timeout_q <= 1'b0;

            irq_q <= ovr_evt | to_evt;
        end
    end

endmodule

// File: tb/tb_spi_sample_sequencer.sv
module tb_spi_sample_sequencer;
    localparam int DW = 16;

    logic clk, rst_n, en, en2, clr, miso, adc_ready, dac_valid;
    logic [DW-1:0] dac_data;
    logic mosi, sclk, adc_cs_n, dac_cs_n, adc_valid, dac_ready, busy, ovr, tmo, irq;
    logic [DW-1:0] adc_data;
    logic d2_mosi, d2_sclk, d2_adc_cs_n, d2_dac_cs_n, d2_adc_valid, d2_dac_ready;
    logic d2_busy, d2_ovr, d2_tmo, d2_irq;
    logic [DW-1:0] d2_adc_data;

    int n_checks = 0;
    int n_err = 0;
    logic [DW-1:0] adc_word;
    logic [DW-1:0] exp_adc_q[$];
    logic [DW-1:0] exp_dac_q[$];
    int dac_frames = 0;
    int d2_irq_cnt = 0;
    int d2_adc_frames = 0;

    spi_sample_sequencer dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .enable_i(en), .clr_status_i(clr),
        .miso_i(miso), .mosi_o(mosi), .sclk_o(sclk), .adc_cs_n_o(adc_cs_n),
        .dac_cs_n_o(dac_cs_n), .adc_data_o(adc_data), .adc_valid_o(adc_valid),
        .adc_ready_i(adc_ready), .dac_data_i(dac_data), .dac_valid_i(dac_valid),
        .dac_ready_o(dac_ready), .busy_o(busy), .overrun_o(ovr), .timeout_o(tmo),
        .irq_o(irq)
    );

    spi_sample_sequencer #(.SAMPLE_DIV(300), .PROC_TIMEOUT(512)) dut2 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .enable_i(en2), .clr_status_i(clr),
        .miso_i(miso), .mosi_o(d2_mosi), .sclk_o(d2_sclk), .adc_cs_n_o(d2_adc_cs_n),
        .dac_cs_n_o(d2_dac_cs_n), .adc_data_o(d2_adc_data), .adc_valid_o(d2_adc_valid),
        .adc_ready_i(adc_ready), .dac_data_i(dac_data), .dac_valid_i(dac_valid),
        .dac_ready_o(d2_dac_ready), .busy_o(d2_busy), .overrun_o(d2_ovr), .timeout_o(d2_tmo),
        .irq_o(d2_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return adc_valid;
            1: return dac_ready;
            2: return dac_cs_n;
            3: return adc_cs_n;
            default: return tmo;
        endcase
    endfunction

    // Bounded wait, evaluated at negedges; an expired bound counts as a failure.
    task automatic wait_neg(input string nm, input int sel, input logic lvl,
                            input int maxc, output int waited);
        waited = 0;
        while (sig(sel) !== lvl && waited < maxc) begin
            @(negedge clk);
            waited++;
        end
        if (sig(sel) !== lvl) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: wait expired after %0d cycles", nm, waited);
        end
    endtask

    // ADC slave model: MSB presented at CS fall, next bit on each sclk fall.
    initial begin
        logic [DW-1:0] sh;
        miso = 1'b0;
        forever begin
            @(negedge adc_cs_n);
            sh = adc_word;
            miso = sh[DW-1];
            for (int b = 1; b < DW; b++) begin
                @(negedge sclk);
                sh = sh << 1;
                miso = sh[DW-1];
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic dac_in, adc_in, sclk_prev, av_prev, d2_irq_prev, d2_cs_prev;
        int dac_len, dac_rises, adc_len, adc_rises;
        logic [DW-1:0] dac_sh, adc_hold, e;
        dac_in = 0; adc_in = 0; sclk_prev = 0; av_prev = 0;
        d2_irq_prev = 0; d2_cs_prev = 1;
        dac_len = 0; dac_rises = 0; adc_len = 0; adc_rises = 0;
        dac_sh = '0; adc_hold = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dac_in = 0; adc_in = 0; sclk_prev = 0; av_prev = 0;
                d2_irq_prev = 0; d2_cs_prev = 1;
                d2_irq_cnt = 0; d2_adc_frames = 0;
            end else begin
                if (!dac_cs_n) begin
                    if (!dac_in) begin dac_in = 1; dac_len = 0; dac_rises = 0; dac_sh = '0; end
                    dac_len++;
                    if (sclk && !sclk_prev) begin dac_sh = {dac_sh[DW-2:0], mosi}; dac_rises++; end
                end else if (dac_in) begin
                    dac_in = 0;
                    dac_frames++;
                    if (exp_dac_q.size() == 0) begin
                        chk("dac_unexpected_frame", 32'(dac_sh), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_dac_q.pop_front();
                        chk("dac_word", 32'(dac_sh), 32'(e));
                    end
                    chk("dac_frame_len", dac_len, 136);
                    chk("dac_sclk_rises", dac_rises, 16);
                end
                if (!adc_cs_n) begin
                    if (!adc_in) begin adc_in = 1; adc_len = 0; adc_rises = 0; end
                    adc_len++;
                    if (sclk && !sclk_prev) adc_rises++;
                    chk("adc_frame_mosi_low", 32'(mosi), 0);
                end else if (adc_in) begin
                    adc_in = 0;
                    chk("adc_frame_len", adc_len, 136);
                    chk("adc_sclk_rises", adc_rises, 16);
                end
                if (adc_valid && !av_prev) begin
                    adc_hold = adc_data;
                    if (exp_adc_q.size() == 0) begin
                        chk("adc_unexpected_valid", 32'(adc_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_adc_q.pop_front();
                        chk("adc_data", 32'(adc_data), 32'(e));
                    end
                end else if (adc_valid) begin
                    chk("adc_data_stable", 32'(adc_data), 32'(adc_hold));
                end
                if (d2_irq && !d2_irq_prev) d2_irq_cnt++;
                if (!d2_adc_cs_n && d2_cs_prev) d2_adc_frames++;
                sclk_prev = sclk;
                av_prev = adc_valid;
                d2_irq_prev = d2_irq;
                d2_cs_prev = d2_adc_cs_n;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        int w;
        rst_n = 1'b0; en = 0; en2 = 0; clr = 0; adc_ready = 0; dac_valid = 0;
        dac_data = '0; adc_word = '0;
        step(3);
        // Reset state
        chk("rst_adc_cs_n", adc_cs_n, 1);
        chk("rst_dac_cs_n", dac_cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_valid_ready", {adc_valid, dac_ready}, 0);
        chk("rst_busy_flags_irq", {busy, ovr, tmo, irq}, 0);
        chk("rst_adc_data", adc_data, 0);
        rst_n = 1'b1;
        step(2);

        // Overrun / clear-vs-set on the short-period instance.
        en2 = 1;                       // N0
        step(299); chk("tick_pre_busy", d2_busy, 0);
        step(1);   chk("tick_busy", {d2_busy, d2_adc_cs_n}, 2'b10);
        step(136); chk("ov_present", {d2_adc_valid, d2_adc_cs_n}, 2'b11);
        step(163); chk("ov_pre_flag", {d2_ovr, d2_irq}, 0);
        step(1);   chk("ov_flag_irq", {d2_ovr, d2_irq}, 2'b11);
        step(1);   chk("ov_irq_single", {d2_ovr, d2_irq}, 2'b10);
        step(298); clr = 1;
        step(1);   clr = 0;
        chk("clr_vs_set_ovr", {d2_ovr, d2_irq}, 2'b11);
        step(58);
        chk("ov_irq_count", d2_irq_cnt, 3);
        chk("ov_no_second_adc", d2_adc_frames, 1);
        chk("ov_timeout_flag", d2_tmo, 1);
        clr = 1;
        step(1);   clr = 0;
        chk("clr_alone", {d2_ovr, d2_tmo}, 0);
        en2 = 0;
        do_reset();

        // Normal period.
        adc_word = 16'hA5C3; adc_ready = 1;
        exp_adc_q.push_back(16'hA5C3);
        exp_dac_q.push_back(16'h1234);
        en = 1;
        wait_neg("norm_adc_valid", 0, 1'b1, 1300, w);
        chk("norm_valid_latency", w, 1178);
        step(1);
        chk("norm_handoff", {adc_valid, dac_ready}, 2'b01);
        step(10);
        dac_data = 16'h1234; dac_valid = 1;
        step(1);
        dac_valid = 0;
        chk("norm_dac_start", {dac_ready, dac_cs_n}, 0);
        wait_neg("norm_dac_end", 2, 1'b1, 300, w);
        chk("norm_dac_cs_len", w, 136);
        step(2);
        chk("norm_idle_before_tick", busy, 0);

        // Timeout: DSP accepts but never returns.
        adc_word = 16'h5A3C;
        exp_adc_q.push_back(16'h5A3C);
        exp_dac_q.push_back(16'h1234);
        wait_neg("to_adc_valid", 0, 1'b1, 1100, w);
        wait_neg("to_flag", 4, 1'b1, 600, w);
        chk("to_latency", w, 512);
        chk("to_irq_dac_start", {irq, dac_cs_n, dac_ready}, 3'b100);
        step(1);
        chk("to_irq_single", {irq, tmo}, 2'b01);
        wait_neg("to_dac_end", 2, 1'b1, 300, w);
        step(1);

        // Disable mid ADC frame.
        wait_neg("dis_adc_start", 3, 1'b0, 1100, w);
        step(20);
        en = 0;
        wait_neg("dis_adc_end", 3, 1'b1, 300, w);
        chk("dis_adc_completes", w, 116);
        step(2);
        chk("dis_adc_idle", {adc_valid, busy}, 0);

        // Disable in WAIT_PROC.
        adc_word = 16'h0001;
        exp_adc_q.push_back(16'h0001);
        en = 1;
        wait_neg("dis_wait_ready", 1, 1'b1, 1300, w);
        en = 0;
        begin
            int fr;
            fr = dac_frames;
            step(1);
            chk("dis_wait_idle", {busy, dac_ready}, 0);
            step(60);
            chk("dis_wait_no_dac", {28'(dac_frames - fr), 3'b0, dac_cs_n}, 1);
        end

        // Async reset mid DAC frame.
        adc_word = 16'h7E81;
        exp_adc_q.push_back(16'h7E81);
        en = 1;
        wait_neg("rst_wait_ready", 1, 1'b1, 1300, w);
        dac_data = 16'hBEEF; dac_valid = 1;
        step(1);
        dac_valid = 0;
        chk("rst_mid_dac_active", dac_cs_n, 0);
        step(40);
        chk("rst_pre_tmo_sticky", tmo, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_cs", {dac_cs_n, adc_cs_n}, 2'b11);
        chk("async_rst_sclk_mosi", {sclk, mosi}, 0);
        chk("async_rst_flags", {busy, ovr, tmo, irq}, 0);
        en = 0;
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("queues_empty", exp_adc_q.size() + exp_dac_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
